// File: rtl/dmc_pkg.sv
// Shared definitions for the direct-mapped cache: geometry, address-field
// widths and the controller state type.
package dmc_pkg;

  localparam int unsigned DMC_NUM_LINES      = 64;
  localparam int unsigned DMC_WORDS_PER_LINE = 16;
  localparam int unsigned DMC_ADDR_W         = 64;
  localparam int unsigned DMC_DATA_W         = 32;
  localparam int unsigned DMC_BYTE_OFF_W     = 2;
  localparam int unsigned DMC_WSEL_W         = $clog2(DMC_WORDS_PER_LINE);
  localparam int unsigned DMC_LINE_ADDR_W    = DMC_ADDR_W - DMC_WSEL_W - DMC_BYTE_OFF_W;
  localparam int unsigned DMC_IDX_W          = $clog2(DMC_NUM_LINES);
  localparam int unsigned DMC_TAG_W          = DMC_LINE_ADDR_W - DMC_IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE,
    RESP
  } dmc_state_e;

endpackage

// File: rtl/dmc_line_store.sv
// Tag/valid/data storage for the direct-mapped cache. One shared index,
// one write port (word and/or tag+valid) and a combinational read port.
module dmc_line_store
  import dmc_pkg::*;
#(
  parameter int unsigned NUM_LINES      = DMC_NUM_LINES,
  parameter int unsigned WORDS_PER_LINE = DMC_WORDS_PER_LINE,
  parameter int unsigned IDX_W          = $clog2(NUM_LINES),
  parameter int unsigned WSEL_W         = $clog2(WORDS_PER_LINE),
  parameter int unsigned TAG_W          = DMC_LINE_ADDR_W - IDX_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic                  wr_word_en_i,
  input  logic [WSEL_W-1:0]     wr_word_sel_i,
  input  logic [DMC_DATA_W-1:0] wr_data_i,
  input  logic                  wr_tag_en_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic                  wr_valid_i,
  input  logic [WSEL_W-1:0]     rd_word_sel_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [DMC_DATA_W-1:0] rd_data_o
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DMC_DATA_W-1:0] data_q [NUM_LINES][WORDS_PER_LINE];

  // Valid bits are the only storage that must come up cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_tag_en_i) begin
      valid_q[idx_i] <= wr_valid_i;
    end
  end

  // Tag and data arrays are plain storage without reset.
  always_ff @(posedge clk) begin
    if (wr_tag_en_i) begin
      tag_q[idx_i] <= wr_tag_i;
    end
    if (wr_word_en_i) begin
      data_q[idx_i][wr_word_sel_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[idx_i][rd_word_sel_i];

endmodule

// File: rtl/direct_map_cache.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a
// single-beat memory bus. Read misses refill the whole line in word order.
module direct_map_cache
  import dmc_pkg::*;
#(
  parameter int unsigned NUM_LINES      = DMC_NUM_LINES,
  parameter int unsigned WORDS_PER_LINE = DMC_WORDS_PER_LINE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       read_write_n,
  input  logic [DMC_LINE_ADDR_W-1:0] line_addr,
  input  logic [DMC_WSEL_W-1:0]      word_select,
  input  logic [DMC_DATA_W-1:0]      data_in,
  output logic                       ack,
  output logic [DMC_DATA_W-1:0]      data_out,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [DMC_ADDR_W-1:0]      bus_addr,
  output logic [DMC_DATA_W-1:0]      bus_wdata,
  input  logic [DMC_DATA_W-1:0]      bus_rdata,
  input  logic                       bus_ack
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = DMC_LINE_ADDR_W - IDX_W;
  localparam logic [DMC_WSEL_W-1:0] LAST_BEAT = DMC_WSEL_W'(WORDS_PER_LINE - 1);

  dmc_state_e                 state_q;
  logic [DMC_LINE_ADDR_W-1:0] line_q;
  logic [DMC_WSEL_W-1:0]      wsel_q;
  logic                       rd_q;
  logic [DMC_DATA_W-1:0]      wdata_q;
  logic [DMC_WSEL_W-1:0]      beat_q, beat_d;

  logic                  ack_q, bus_req_q, bus_we_q;
  logic [DMC_DATA_W-1:0] data_out_q, bus_wdata_q;
  logic [DMC_ADDR_W-1:0] bus_addr_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  st_valid, hit;
  logic [TAG_W-1:0]      st_tag;
  logic [DMC_DATA_W-1:0] st_word;

  logic                  wr_word_en, wr_tag_en, wr_valid;
  logic [DMC_WSEL_W-1:0] wr_word_sel;
  logic [DMC_DATA_W-1:0] wr_data;

  assign idx    = line_q[IDX_W-1:0];
  assign tag    = line_q[DMC_LINE_ADDR_W-1:IDX_W];
  assign hit    = st_valid && (st_tag == tag);
  assign beat_d = beat_q + 1'b1;

  dmc_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .WSEL_W         (DMC_WSEL_W),
    .TAG_W          (TAG_W)
  ) u_store (
    .clk           (clk),
    .reset         (reset),
    .idx_i         (idx),
    .wr_word_en_i  (wr_word_en),
    .wr_word_sel_i (wr_word_sel),
    .wr_data_i     (wr_data),
    .wr_tag_en_i   (wr_tag_en),
    .wr_tag_i      (tag),
    .wr_valid_i    (wr_valid),
    .rd_word_sel_i (wsel_q),
    .rd_valid_o    (st_valid),
    .rd_tag_o      (st_tag),
    .rd_data_o     (st_word)
  );

  // Store write port: write-hit update, line invalidate on miss, refill beats.
  always_comb begin
    wr_word_en  = 1'b0;
    wr_word_sel = wsel_q;
    wr_data     = wdata_q;
    wr_tag_en   = 1'b0;
    wr_valid    = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (rd_q) begin
          // Invalidate up front so an interrupted refill never looks valid.
          wr_tag_en = !hit;
        end else begin
          wr_word_en = hit;
        end
      end
      REFILL: begin
        if (bus_ack) begin
          wr_word_en  = 1'b1;
          wr_word_sel = beat_q;
          wr_data     = bus_rdata;
          if (beat_q == LAST_BEAT) begin
            wr_tag_en = 1'b1;
            wr_valid  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with registered requester and bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      line_q      <= '0;
      wsel_q      <= '0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      ack_q       <= 1'b0;
      data_out_q  <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            line_q  <= line_addr;
            wsel_q  <= word_select;
            rd_q    <= read_write_n;
            wdata_q <= data_in;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rd_q && hit) begin
            ack_q      <= 1'b1;
            data_out_q <= st_word;
            state_q    <= RESP;
          end else if (rd_q) begin
            beat_q     <= '0;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= {line_q, {DMC_WSEL_W{1'b0}}, 2'b00};
            state_q    <= REFILL;
          end else begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b1;
            bus_addr_q  <= {line_q, wsel_q, 2'b00};
            bus_wdata_q <= wdata_q;
            state_q     <= WRITE;
          end
        end
        REFILL: begin
          if (bus_ack) begin
            if (beat_q == LAST_BEAT) begin
              bus_req_q  <= 1'b0;
              ack_q      <= 1'b1;
              // The requested word may be the one arriving this cycle.
              data_out_q <= (wsel_q == beat_q) ? bus_rdata : st_word;
              beat_q     <= '0;
              state_q    <= RESP;
            end else begin
              beat_q     <= beat_d;
              bus_addr_q <= {line_q, beat_d, 2'b00};
            end
          end
        end
        WRITE: begin
          if (bus_ack) begin
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            ack_q      <= 1'b1;
            data_out_q <= '0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          ack_q      <= 1'b0;
          data_out_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign data_out  = data_out_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_direct_map_cache.sv
// Bench for direct_map_cache: table of directed accesses, reset-abort and
// back-to-back sequences, then random traffic against a behavioural model.
module tb_direct_map_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        read_write_n;
  logic [57:0] line_addr;
  logic [3:0]  word_select;
  logic [31:0] data_in;
  logic        ack;
  logic [31:0] data_out;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  direct_map_cache #(.NUM_LINES(64), .WORDS_PER_LINE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .read_write_n (read_write_n),
    .line_addr    (line_addr),
    .word_select  (word_select),
    .data_in      (data_in),
    .ack          (ack),
    .data_out     (data_out),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  always #5 clk = ~clk;

  // Bus memory: untouched words read back as their own byte address.
  typedef struct { logic we; logic [63:0] addr; logic [31:0] wdata; } beat_t;
  beat_t       bus_log[$];
  logic [31:0] bus_mem [logic [63:0]];
  bit          rand_wait = 0;
  int unsigned wait_cnt = 0;

  function automatic logic [31:0] bus_mem_rd(input logic [63:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : a[31:0];
  endfunction

  always @(negedge clk) begin
    bus_ack = 1'b0;
    if (reset) begin
      wait_cnt = 0;
    end else if (bus_req) begin
      if (wait_cnt != 0) begin
        wait_cnt--;
      end else begin
        bus_ack = 1'b1;
        if (bus_we) bus_mem[bus_addr] = bus_wdata;
        else        bus_rdata = bus_mem_rd(bus_addr);
        bus_log.push_back('{bus_we, bus_addr, bus_wdata});
        wait_cnt = rand_wait ? $urandom_range(0, 2) : 0;
      end
    end
  end

  // Reference model: which line address each index holds, and memory contents.
  bit          ref_valid [64];
  logic [57:0] ref_tag   [64];
  logic [31:0] ref_mem   [logic [63:0]];

  function automatic int model_access(input logic rw, input logic [57:0] line,
                                      input logic [3:0] ws, input logic [31:0] din,
                                      output logic [31:0] exp_data);
    int          idx;
    logic [63:0] a;
    idx = int'(line % 64);
    a   = 64'(line) * 64 + 64'(ws) * 4;
    if (rw) begin
      exp_data = ref_mem.exists(a) ? ref_mem[a] : a[31:0];
      if (ref_valid[idx] && ref_tag[idx] == line / 64) return 0;
      ref_valid[idx] = 1;
      ref_tag[idx]   = line / 64;
      return 16;
    end
    ref_mem[a] = din;
    exp_data   = '0;
    return 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input logic rw, input logic [57:0] line, input logic [3:0] ws,
                           input logic [31:0] din, output logic [31:0] got,
                           output int lat, output bit ok);
    bus_log.delete();
    req = 1'b1; read_write_n = rw; line_addr = line; word_select = ws; data_in = din;
    lat = 0; ok = 0; got = '0;
    while (lat < 400 && !ok) begin
      @(negedge clk);
      lat++;
      if (ack) begin
        ok  = 1;
        got = data_out;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack required ack within 400 cycles line=%0h", line);
    end
  endtask

  task automatic go_idle();
    req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 64'(ack), 64'(0));
    check("idle_bus_req", 64'(bus_req), 64'(0));
  endtask

  task automatic check_beats(input logic rw, input logic [57:0] line, input logic [3:0] ws,
                             input logic [31:0] din, input int exp_n);
    check("beat_count", 64'(bus_log.size()), 64'(exp_n));
    if (bus_log.size() == exp_n) begin
      for (int i = 0; i < exp_n; i++) begin
        logic [63:0] ea;
        ea = rw ? 64'(line) * 64 + 64'(i) * 4 : 64'(line) * 64 + 64'(ws) * 4;
        check("beat_addr", bus_log[i].addr, ea);
        check("beat_we", 64'(bus_log[i].we), 64'(!rw));
        if (!rw) check("beat_wdata", 64'(bus_log[i].wdata), 64'(din));
      end
    end
  endtask

  task automatic apply_reset();
    req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic rw; logic [57:0] line; logic [3:0] ws; logic [31:0] din;
    logic [31:0] exp_data; int exp_beats; int exp_lat;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish required finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got, exp_data;
    int          lat, nb;
    bit          ok, found;
    logic        rw;
    logic [57:0] line;
    logic [3:0]  ws;
    logic [31:0] din;

    vecs[0] = '{1'b1, 58'h10, 4'd3, 32'h0,        32'h40C,      16, 18};
    vecs[1] = '{1'b1, 58'h10, 4'd5, 32'h0,        32'h414,       0,  2};
    vecs[2] = '{1'b0, 58'h10, 4'd5, 32'hDEADBEEF, 32'h0,         1,  3};
    vecs[3] = '{1'b1, 58'h10, 4'd5, 32'h0,        32'hDEADBEEF,  0,  2};
    vecs[4] = '{1'b1, 58'h50, 4'd0, 32'h0,        32'h1400,     16, 18};
    vecs[5] = '{1'b1, 58'h10, 4'd5, 32'h0,        32'hDEADBEEF, 16, 18};
    vecs[6] = '{1'b0, 58'h22, 4'd1, 32'h12345678, 32'h0,         1,  3};
    vecs[7] = '{1'b1, 58'h22, 4'd1, 32'h0,        32'h12345678, 16, 18};

    reset = 1'b1; req = 1'b0; read_write_n = 1'b1;
    line_addr = '0; word_select = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_bus_req", 64'(bus_req), 64'(0));
    check("rst_bus_we", 64'(bus_we), 64'(0));
    check("rst_bus_addr", bus_addr, 64'(0));
    check("rst_bus_wdata", 64'(bus_wdata), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      do_access(vecs[k].rw, vecs[k].line, vecs[k].ws, vecs[k].din, got, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d_data", k), 64'(got), 64'(vecs[k].exp_data));
        check($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
        check_beats(vecs[k].rw, vecs[k].line, vecs[k].ws, vecs[k].din, vecs[k].exp_beats);
      end
      go_idle();
    end

    // Reset while beat 7 of a refill is on the bus.
    bus_log.delete();
    req = 1'b1; read_write_n = 1'b1; line_addr = 58'h33; word_select = 4'd2;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus_req && bus_addr == 64'hCDC) found = 1;
    end
    check("reach_beat7", 64'(found), 64'(1));
    reset = 1'b1;
    #1;
    check("abort_bus_req", 64'(bus_req), 64'(0));
    check("abort_ack", 64'(ack), 64'(0));
    req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_access(1'b1, 58'h33, 4'd2, 32'h0, got, lat, ok);
    if (ok) begin
      check("abort_reread_data", 64'(got), 64'h0CC8);
      check_beats(1'b1, 58'h33, 4'd2, 32'h0, 16);
    end
    go_idle();
    do_access(1'b1, 58'h10, 4'd5, 32'h0, got, lat, ok);
    if (ok) begin
      check("post_reset_miss_data", 64'(got), 64'hDEADBEEF);
      check_beats(1'b1, 58'h10, 4'd5, 32'h0, 16);
    end

    // Back-to-back: req stays high across the ack.
    do_access(1'b1, 58'h10, 4'd3, 32'h0, got, lat, ok);
    if (ok) begin
      check("b2b_data", 64'(got), 64'h40C);
      check("b2b_latency", 64'(lat), 64'(3));
      check_beats(1'b1, 58'h10, 4'd3, 32'h0, 0);
    end
    go_idle();

    // Random traffic in a fresh address region, variable bus wait states.
    apply_reset();
    foreach (ref_valid[i]) ref_valid[i] = 0;
    rand_wait = 1;
    for (int n = 0; n < 300; n++) begin
      rw   = ($urandom_range(0, 2) != 0);
      line = 58'((256 + $urandom_range(0, 3)) * 64 + $urandom_range(0, 7));
      ws   = 4'($urandom_range(0, 15));
      din  = $urandom;
      nb   = model_access(rw, line, ws, din, exp_data);
      do_access(rw, line, ws, din, got, lat, ok);
      if (ok) begin
        check("rand_data", 64'(got), 64'(exp_data));
        check_beats(rw, line, ws, din, nb);
      end
      if ($urandom_range(0, 1) != 0) go_idle();
    end
    req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/direct_map_cache.md
DIRECT_MAP_CACHE -- requirements
Module: direct_map_cache

Interface
REQ-001 Parameter NUM_LINES, default 64, number of cache lines (power of two; index width IDX_W = log2(NUM_LINES) = 6).
REQ-002 Parameter WORDS_PER_LINE, default 16, 32-bit words per 64-byte line (word_select width 4).
REQ-003 Clocking SHALL be one clock and reset SHALL be asynchronous and active-high: clk, reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req  in  1  requester access request, held until ack.
REQ-007 read_write_n  in  1  1 = read, 0 = write.
REQ-008 line_addr  in  58  byte address [63:6]; index = line_addr[IDX_W-1:0], tag = remaining upper bits (52 bits at default).
REQ-009 word_select  in  4  word within line (byte address [5:2]).
REQ-010 data_in  in  32  write data.
REQ-011 ack  out  1  one-cycle completion pulse.
REQ-012 data_out  out  32  read data, valid in the ack cycle.
REQ-013 bus_req  out  1  memory-bus beat request.
REQ-014 bus_we  out  1  1 = bus write beat.
REQ-015 bus_addr  out  64  word-aligned byte address of the beat (bits [1:0] = 0).
REQ-016 bus_wdata  out  32  bus write data.
REQ-017 bus_rdata  in  32  bus read data, valid with bus_ack.
REQ-018 bus_ack  in  1  beat completion, one cycle.

Function
REQ-019 FSM states: IDLE, LOOKUP, REFILL, WRITE, RESP.
REQ-020 IDLE: req=1 -> register request fields, go to LOOKUP.
REQ-021 LOOKUP read hit (valid[index] and tag match) -> RESP; ack=1 with data_out = stored word one cycle after LOOKUP (read hit latency 2 cycles from req sampled to ack).
REQ-022 LOOKUP read miss -> REFILL; beats issued for words 0..15 in order, bus_addr = {line_addr, beat[3:0], 2'b00}, bus_we=0.
REQ-023 REFILL: bus_req held until bus_ack; each bus_ack writes bus_rdata into word beat of the line; the next beat's address presents on the following cycle.
REQ-024 After beat 15 is acked: tag written, valid set, -> RESP with the requested word; miss latency = 16 beats + 2 cycles.
REQ-025 Write policy: write-through, no-write-allocate; LOOKUP write -> WRITE; on hit the cached word updated in the same cycle the state moves to WRITE.
REQ-026 WRITE: bus_req=1, bus_we=1, bus_addr = {line_addr, word_select, 2'b00}, bus_wdata = data_in until bus_ack -> RESP (ack, data_out = 0).
REQ-027 Write miss SHALL NOT change any valid bit, tag or data.
REQ-028 RESP: ack=1 for exactly one cycle, then IDLE; if req remains 1 in IDLE, a new transaction starts (back-to-back fetch supported).
REQ-029 ack, bus_req SHALL be 0 in IDLE and LOOKUP; req deassertion before ack is illegal (behaviour undefined).
REQ-030 Line refill overwrites any previous line at that index (direct-mapped eviction, no writeback).

Reset
REQ-031 On reset: state IDLE, all valid bits 0, ack=0, data_out=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, beat counter 0.
REQ-032 Reset mid-refill aborts; the partially filled line SHALL remain invalid.
REQ-033 Tag and data arrays need no reset.

Structure
REQ-034 Shared package dmc_pkg: NUM_LINES, WORDS_PER_LINE, address-field widths, state enum type.
REQ-035 One sub-module dmc_line_store: tag/valid/data arrays, one write port (word or tag/valid) and one combinational read port.

Verification
REQ-036 After reset, read line_addr=0x10, word 3 -> 16 bus reads at 0x400..0x43C; bus_rdata = address; ack with data_out=0x40C.
REQ-037 Repeat same read, word 5 -> no bus_req, ack 2 cycles after req, data_out=0x414.
REQ-038 Write 0xDEADBEEF to line 0x10 word 5 -> bus write at 0x414; subsequent read returns 0xDEADBEEF without bus traffic.
REQ-039 Read line_addr=0x50 (same index 0x10, different tag) -> refill from 0x1400; then line 0x10 read misses again.
REQ-040 Write to uncached line 0x22 -> one bus write, no refill; next read of 0x22 misses.
REQ-041 Assert reset during beat 7 of a refill -> bus_req=0 immediately; re-read of that line performs a full 16-beat refill.
